sfifo_wr_packer: RTL and testbench
==================================

// Module: sfifo_wr_packer
// PURPOSE
//  Width-up packer on the write side of sfifo, same clock domain (wclk).
//  - Collects RATIO narrow beats from a valid/ready source into one OUT_W word.
//  - Writes each word into sfifo through its winc/wdata/wfull interface.
//  - Holds the completed word and stalls the source while the FIFO reports full.
// PARAMETERS
//  IN_W    2   source beat width, bits
//  OUT_W   8   word width, bits; must equal sfifo WIDTH and be RATIO*IN_W, RATIO>=2
//  CNT_W   16  width of the wrapping word counter wr_words
//  (local) RATIO = OUT_W/IN_W; BW = $clog2(RATIO)
// PORTS
//  wclk      in   1         clock, rising edge
//  rst_n     in   1         reset, asynchronous, active-low
//  in_valid  in   1         source beat valid
//  in_ready  out  1         packer accepts beat this cycle
//  in_data   in   IN_W      source beat
//  in_last   in   1         (PACK_LAST_EN only) beat closes current word early
//  wfull     in   1         sfifo full flag
//  winc      out  1         sfifo write strobe
//  wdata     out  OUT_W     sfifo write data
//  wkeep     out  RATIO     (PACK_LAST_EN only) valid lanes of wdata, lane0=LSBs
//  wr_words  out  CNT_W     count of words accepted by sfifo, wraps
// BEHAVIOUR
//  - Reset (async): beat cnt=0, pack reg=0, pend=0, wdata=0, wr_words=0, wkeep=0.
//    Outputs in reset: winc=0, in_ready=1. Mid-operation reset discards any partial
//    or pending word; no winc in the cycle after release unless a word is completed.
//  - Beat accept: acc = in_valid & in_ready. Beat k lands in pack bits
//    [k*IN_W +: IN_W]; first beat occupies the LSBs.
//  - Word complete: acc & (cnt==RATIO-1 [| in_last]).
//    - Word (with the final beat merged) moves into the output reg; pend<=1; cnt<=0.
//    - Pack reg clears to 0 for the next word.
//    - Otherwise acc gives cnt<=cnt+1.
//  - Drain: winc = pend & !wfull, combinational. A word is accepted by sfifo when
//    winc=1; then pend<=0 and wr_words<=wr_words+1 (mod 2^CNT_W).
//  - in_ready = !pend | !wfull. A new beat is accepted while the held word drains.
//  - Simultaneous drain + word complete: pend stays 1, output reg takes the new
//    word, wr_words increments once. Back-to-back words drain one per cycle.
//  - wfull=1 with pend=1: winc=0, in_ready=0; wdata/wkeep held stable.
//  - wdata, wkeep and wr_words are registered; latency from final beat accept to
//    winc is 1 cycle when wfull=0.
//  - State summary: FILL(cnt 0..RATIO-1, pend=0), HOLD(pend=1, FIFO full),
//    FILL+PEND(pend=1, draining). Implemented as cnt + pend; no other state.
//  - wfull is sampled as given; the packer keeps no FIFO occupancy of its own.
// CONFIGURATION
//  PACK_LAST_EN defined:
//    - in_last and wkeep ports exist.
//    - A beat with in_last=1 completes the word at any cnt; unfilled upper lanes
//      of wdata are 0; wkeep has bits [0..cnt] set, others 0.
//    - A full word gives wkeep = all ones.
//    - in_last at cnt==RATIO-1 behaves exactly like a normal full word.
//  PACK_LAST_EN undefined:
//    - in_last and wkeep ports absent; only full RATIO-beat words are emitted.
// TESTING
//  1 Reset, then beats 2'b01,2'b10,2'b11,2'b00 back-to-back, wfull=0 -> one cycle
//    later winc=1, wdata=8'h39, wr_words=1.
//  2 Continuous beats for 4 words, wfull=0 -> 4 winc pulses, one per 4 cycles,
//    data in order; in_ready stays 1.
//  3 Word pending and wfull=1 for 10 cycles -> winc=0, in_ready=0 once the next
//    word fills; wfull->0 -> held word written, then next word; no loss or dup.
//  4 Assert rst_n=0 after 2 of 4 beats -> no winc, wr_words=0; after release a
//    fresh 4-beat word yields exactly one write.
//  5 PACK_LAST_EN: beats 2'b11,2'b01 with in_last on 2nd -> wdata=8'h07, wkeep=4'b0011.
//  6 wr_words with CNT_W=4 after 17 words -> reads 1 (wrap).

Source files
------------

// File: rtl/sfifo_wr_packer.sv
// Width-up packer: gathers OUT_W/IN_W narrow beats into one word and writes it to sfifo.
// Optional feature macro PACK_LAST_EN adds in_last (early word close) and wkeep lane mask.
module sfifo_wr_packer #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     wclk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
`ifdef PACK_LAST_EN
  input  logic                     in_last,
  output logic [OUT_W/IN_W-1:0]    wkeep,
`endif
  input  logic                     wfull,
  output logic                     winc,
  output logic [OUT_W-1:0]         wdata,
  output logic [CNT_W-1:0]         wr_words
);

  localparam int unsigned RATIO = OUT_W / IN_W;
  localparam int unsigned BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  logic [BW-1:0]    cnt;
  logic [OUT_W-1:0] pack;
  logic [OUT_W-1:0] merged;
  logic             pend;
  logic             acc;
  logic             close;
  logic             done;

  // The held word drains whenever sfifo has room; the source stalls only when it cannot.
  assign winc     = pend & ~wfull;
  assign in_ready = ~pend | ~wfull;
  assign acc      = in_valid & in_ready;

`ifdef PACK_LAST_EN
  assign close = (cnt == LAST_BEAT) | in_last;
`else
  assign close = (cnt == LAST_BEAT);
`endif
  assign done = acc & close;

  // Pack register with the current beat dropped into its lane.
  always_comb begin
    merged = pack;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (BW'(i) == cnt) merged[i*IN_W +: IN_W] = in_data;
    end
  end

`ifdef PACK_LAST_EN
  logic [RATIO-1:0] keep_c;

  // Lanes 0..cnt are valid in a word closed at beat cnt.
  always_comb begin
    keep_c = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      keep_c[i] = (BW'(i) <= cnt);
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wkeep <= '0;
    end else if (done) begin
      wkeep <= keep_c;
    end
  end
`endif

  // Beat counter, pack register, held word and pending flag.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pack  <= '0;
      pend  <= 1'b0;
      wdata <= '0;
    end else if (done) begin
      wdata <= merged;
      pack  <= '0;
      cnt   <= '0;
      pend  <= 1'b1;
    end else begin
      if (acc) begin
        pack <= merged;
        cnt  <= cnt + BW'(1);
      end
      if (winc) pend <= 1'b0;
    end
  end

  // Words accepted by sfifo, wrapping.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_words <= '0;
    end else if (winc) begin
      wr_words <= wr_words + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sfifo_wr_packer.sv
// Self-checking bench for sfifo_wr_packer: queue-based reference model plus directed literals.
// Exercises PACK_LAST_EN paths only when that macro is defined.
module tb_sfifo_wr_packer;

  localparam int unsigned IN_W  = 2;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned RATIO = OUT_W / IN_W;

  logic             wclk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             wfull;
  logic             winc;
  logic [OUT_W-1:0] wdata;
  logic [CNT_W-1:0] wr_words;
`ifdef PACK_LAST_EN
  logic [RATIO-1:0] wkeep;
`endif

  int checks = 0;
  int fails  = 0;

  sfifo_wr_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .wclk     (wclk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef PACK_LAST_EN
    .in_last  (in_last),
    .wkeep    (wkeep),
`endif
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .wr_words (wr_words)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: partial word as a list of beats, held word as a 0/1-entry queue.
  logic [IN_W-1:0]  beats_q[$];
  logic [OUT_W-1:0] held_q[$];
  logic [RATIO-1:0] held_keep;
  int unsigned      exp_words;

  always @(posedge wclk or negedge rst_n) begin : model
    bit drain, rdy, lst;
    logic [OUT_W-1:0] word;
    if (!rst_n) begin
      beats_q.delete();
      held_q.delete();
      held_keep = '0;
      exp_words = 0;
    end else begin
      drain = (held_q.size() != 0) && !wfull;
      rdy   = (held_q.size() == 0) || !wfull;
`ifdef PACK_LAST_EN
      lst = in_last;
`else
      lst = 1'b0;
`endif
      if (drain) begin
        void'(held_q.pop_front());
        exp_words = (exp_words + 1) % (1 << CNT_W);
      end
      if (in_valid && rdy) begin
        beats_q.push_back(in_data);
        if (beats_q.size() == RATIO || lst) begin
          word = '0;
          foreach (beats_q[k]) word = word | (OUT_W'(beats_q[k]) << (k * IN_W));
          held_q.push_back(word);
          held_keep = RATIO'((1 << beats_q.size()) - 1);
          beats_q.delete();
        end
      end
    end
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge wclk) begin
    check("winc", 32'(winc), 32'((held_q.size() != 0) && !wfull));
    check("in_ready", 32'(in_ready), 32'((held_q.size() == 0) || !wfull));
    check("wr_words", 32'(wr_words), 32'(exp_words));
    if (held_q.size() != 0) begin
      check("wdata", 32'(wdata), 32'(held_q[0]));
`ifdef PACK_LAST_EN
      check("wkeep", 32'(wkeep), 32'(held_keep));
`endif
    end
  end

  task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 100; t++) begin
      @(negedge wclk);
      ok = in_ready;
      @(posedge wclk);
      #1;
      if (ok) break;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1 within 100 cycles at %0t", $time);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; wfull = 1'b0;
    idle(3);
    @(negedge wclk);
    check("rst_winc", 32'(winc), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_wr_words", 32'(wr_words), 32'd0);
    @(posedge wclk); #1;
    rst_n = 1'b1;

    // Single word, literal result 8'h39.
    send_beat(2'b01, 1'b0);
    send_beat(2'b10, 1'b0);
    send_beat(2'b11, 1'b0);
    send_beat(2'b00, 1'b0);
    @(negedge wclk);
    check("t1_winc", 32'(winc), 32'd1);
    check("t1_wdata", 32'(wdata), 32'h39);
    @(posedge wclk); #1;
    @(negedge wclk);
    check("t1_wr_words", 32'(wr_words), 32'd1);
    @(posedge wclk); #1;

    // Four back-to-back words.
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < int'(RATIO); k++)
        send_beat(IN_W'(w + 3 * k), 1'b0);
    idle(3);
    @(negedge wclk);
    check("t2_wr_words", 32'(wr_words), 32'd5);
    @(posedge wclk); #1;

    // Hold a word under wfull, then release while the next word is offered.
    wfull = 1'b1;
    for (int k = 0; k < int'(RATIO); k++) send_beat(IN_W'(k), 1'b0);
    @(negedge wclk);
    check("t3_hold_winc", 32'(winc), 32'd0);
    check("t3_hold_in_ready", 32'(in_ready), 32'd0);
    check("t3_hold_wdata", 32'(wdata), 32'he4);
    @(posedge wclk); #1;
    fork
      begin
        idle(10);
        wfull = 1'b0;
      end
      for (int k = 0; k < int'(RATIO); k++) send_beat(IN_W'(3 - k), 1'b0);
    join
    idle(3);
    @(negedge wclk);
    check("t3_wr_words", 32'(wr_words), 32'd7);
    @(posedge wclk); #1;

    // Reset in the middle of a word.
    send_beat(2'b11, 1'b0);
    send_beat(2'b11, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge wclk);
    check("t4_rst_winc", 32'(winc), 32'd0);
    check("t4_rst_wr_words", 32'(wr_words), 32'd0);
    check("t4_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge wclk); #1;
    rst_n = 1'b1;
    idle(2);
    for (int k = 0; k < int'(RATIO); k++) send_beat(IN_W'(k + 1), 1'b0);
    idle(3);
    @(negedge wclk);
    check("t4_wr_words", 32'(wr_words), 32'd1);
    @(posedge wclk); #1;

`ifdef PACK_LAST_EN
    // Early close and close on the final beat.
    send_beat(2'b11, 1'b0);
    send_beat(2'b01, 1'b1);
    @(negedge wclk);
    check("t5_wdata", 32'(wdata), 32'h07);
    check("t5_wkeep", 32'(wkeep), 32'h3);
    @(posedge wclk); #1;
    send_beat(2'b10, 1'b1);
    for (int k = 0; k < int'(RATIO); k++) send_beat(IN_W'(k), (k == int'(RATIO) - 1));
    idle(3);
`endif

    // Counter wraps at 2^CNT_W words.
    do_reset();
    for (int w = 0; w < 17; w++)
      for (int k = 0; k < int'(RATIO); k++)
        send_beat(IN_W'(w + k), 1'b0);
    idle(3);
    @(negedge wclk);
    check("t6_wr_words_wrap", 32'(wr_words), 32'd1);
    @(posedge wclk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
